branch_predictor_btb: RTL and testbench

- Parametrised branch target buffer with per-entry saturating direction counters.
- Sits beside the PC in IF. It predicts next-PC for branches and jumps in the same cycle as fetch.
- Resolved outcomes from the MEM stage train the table and raise a redirect on misprediction.
- Generalises the fixed PC+4/BTA/jump mux chain to prediction with configurable depth, counter width and address width, and adds statistics counters.

---
 rtl/branch_predictor_btb_pkg.sv | 15 +
 rtl/branch_predictor_btb_sat_counter.sv | 23 ++
 rtl/branch_predictor_btb.sv | 135 +++++++++++++
 tb/tb_branch_predictor_btb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants and helpers for the branch target buffer.
// The entry layout depends on the instance parameters, so the top builds the entry struct from these.
package branch_predictor_btb_pkg;

    localparam int PC_INC = 4;

    function automatic int weak_taken(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down direction counter: next value from current value and a training request.
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             inc,
    input  logic             dec,
    input  logic             force_max,
    output logic [CNT_W-1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (force_max) begin
            cnt_out = '1;
        end else if (inc && (cnt_in != '1)) begin
            cnt_out = cnt_in + CNT_W'(1);
        end else if (dec && (cnt_in != '0)) begin
            cnt_out = cnt_in - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: zero-latency lookup in IF, registered training from MEM,
// combinational redirect on misprediction, and saturating lookup/mispredict statistics.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              flush_all,
    output logic              mispredict,
    output logic [ADDR_W-1:0] correct_pc,
    output logic [STAT_W-1:0] lookup_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [CNT_W-1:0] WEAK_TAKEN = CNT_W'(weak_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(cnt_max(CNT_W));

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CNT_W-1:0]  cnt;
    } entry_t;

    entry_t              entries_q [ENTRIES];
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [STAT_W-1:0]   lookup_count_q, lookup_count_d;
    logic [STAT_W-1:0]   mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0]    lk_idx, up_idx;
    logic [TAG_W-1:0]    lk_tag, up_tag;
    entry_t              lk_entry, up_entry, wr_entry;
    logic                lk_hit, up_hit, wr_en;
    logic [CNT_W-1:0]    cnt_next;

    assign lk_idx   = lookup_pc[IDX_W+1:2];
    assign lk_tag   = lookup_pc[ADDR_W-1:IDX_W+2];
    assign lk_entry = entries_q[lk_idx];
    assign lk_hit   = valid_q[lk_idx] && (lk_entry.tag == lk_tag);

    assign pred_taken  = lookup_valid && lk_hit && lk_entry.cnt[CNT_W-1];
    assign pred_target = pred_taken ? lk_entry.target : lookup_pc + ADDR_W'(PC_INC);

    assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(PC_INC);

    assign up_idx   = upd_pc[IDX_W+1:2];
    assign up_tag   = upd_pc[ADDR_W-1:IDX_W+2];
    assign up_entry = entries_q[up_idx];
    assign up_hit   = valid_q[up_idx] && (up_entry.tag == up_tag);

    sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .cnt_in    (up_entry.cnt),
        .inc       (upd_taken),
        .dec       (!upd_taken),
        .force_max (upd_is_jump),
        .cnt_out   (cnt_next)
    );

    // Flush beats training: no table write at all while the valid bits are being cleared.
    always_comb begin
        valid_d  = valid_q;
        wr_en    = 1'b0;
        wr_entry = up_entry;
        if (flush_all) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (up_hit) begin
                wr_en        = 1'b1;
                wr_entry.cnt = cnt_next;
                if (upd_taken || upd_is_jump) begin
                    wr_entry.target = upd_target;
                end
            end else if (upd_taken) begin
                wr_en           = 1'b1;
                valid_d[up_idx] = 1'b1;
                wr_entry.tag    = up_tag;
                wr_entry.target = upd_target;
                wr_entry.cnt    = upd_is_jump ? CNT_MAX : WEAK_TAKEN;
            end
        end
    end

    always_comb begin
        lookup_count_d     = lookup_count_q;
        mispredict_count_d = mispredict_count_q;
        if (lookup_valid && (lookup_count_q != '1)) begin
            lookup_count_d = lookup_count_q + STAT_W'(1);
        end
        if (mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q            <= '0;
            lookup_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            lookup_count_q     <= lookup_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries_q[up_idx] <= wr_entry;
        end
    end

    assign lookup_count     = lookup_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb with a behavioural table model checked every cycle.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] lookup_count;
    logic [31:0] mispredict_count;

    int n_checks = 0;
    int n_pass   = 0;

    branch_predictor_btb dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_jump      (upd_is_jump),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .flush_all        (flush_all),
        .mispredict       (mispredict),
        .correct_pc       (correct_pc),
        .lookup_count     (lookup_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: 16 direct-mapped slots, 2-bit counters, taken when counter >= 2.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_cnt   [16];
    longint      m_lookups = 0;
    longint      m_mispred = 0;

    function automatic int unsigned slot_of(input int unsigned pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken();
        return lookup_valid && m_hit(lookup_pc) && (m_cnt[slot_of(lookup_pc)] >= 2);
    endfunction

    function automatic int unsigned m_pred_target();
        if (m_pred_taken()) return m_tgt[slot_of(lookup_pc)];
        return lookup_pc + 4;
    endfunction

    function automatic bit m_mispredict();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge rst) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_lookups = 0;
        m_mispred = 0;
    end

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            int unsigned s;
            s = slot_of(upd_pc);
            if (lookup_valid && m_lookups < 64'hFFFF_FFFF) m_lookups++;
            if (m_mispredict() && m_mispred < 64'hFFFF_FFFF) m_mispred++;
            if (flush_all) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            end else if (upd_valid) begin
                if (m_hit(upd_pc)) begin
                    if (upd_is_jump) m_cnt[s] = 3;
                    else if (upd_taken) m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
                    else m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
                    if (upd_taken || upd_is_jump) m_tgt[s] = upd_target;
                end else if (upd_taken) begin
                    m_valid[s] = 1'b1;
                    m_tag[s]   = tag_of(upd_pc);
                    m_tgt[s]   = upd_target;
                    m_cnt[s]   = upd_is_jump ? 3 : 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("pred_taken", pred_taken, m_pred_taken());
            check("pred_target", pred_target, m_pred_target());
            check("mispredict", mispredict, m_mispredict());
            check("correct_pc", correct_pc, upd_taken ? upd_target : upd_pc + 32'd4);
            check("lookup_count", lookup_count, m_lookups);
            check("mispredict_count", mispredict_count, m_mispred);
        end
    end

    task automatic idle();
        lookup_valid = 0; lookup_pc = 0; upd_valid = 0; upd_pc = 0; upd_is_jump = 0;
        upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0; flush_all = 0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_valid = 1; lookup_pc = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                       input logic [31:0] tgt, input logic ptkn, input logic [31:0] ptgt);
        upd_valid = 1; upd_pc = pc; upd_is_jump = jmp; upd_taken = tkn;
        upd_target = tgt; upd_pred_taken = ptkn; upd_pred_target = ptgt;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        look(32'h40);
        #16 rst = 1'b1;
        settle();
        check("rst_pred_taken", pred_taken, 0);
        check("rst_pred_target", pred_target, 32'h44);
        check("rst_lookup_count", lookup_count, 0);
        check("rst_mispredict_count", mispredict_count, 0);

        next(); upd(32'h40, 0, 1, 32'h100, 0, 0);
        settle();
        check("alloc_mispredict", mispredict, 1);
        check("alloc_correct_pc", correct_pc, 32'h100);
        next(); look(32'h40);
        settle();
        check("alloc_hit_taken", pred_taken, 1);
        check("alloc_hit_target", pred_target, 32'h100);
        check("alloc_mispredict_count", mispredict_count, 1);

        next(); upd(32'h40, 0, 0, 0, 0, 0); look(32'h40);
        settle();
        check("same_cycle_old_view", pred_taken, 1);
        next(); look(32'h40);
        settle();
        check("after_dec_not_taken", pred_taken, 0);
        for (int i = 0; i < 3; i++) begin
            next(); upd(32'h40, 0, 0, 0, 0, 0);
        end
        next(); upd(32'h40, 0, 1, 32'h100, 0, 0);
        next(); look(32'h40);
        settle();
        check("sat_low_one_taken", pred_taken, 0);
        next(); upd(32'h40, 0, 1, 32'h100, 0, 0);
        next(); look(32'h40);
        settle();
        check("sat_low_two_taken", pred_taken, 1);

        next(); upd(32'h80, 0, 1, 32'h180, 0, 0);
        next(); look(32'h40);
        settle();
        check("alias_evicted_taken", pred_taken, 0);
        check("alias_evicted_target", pred_target, 32'h44);
        next(); look(32'h80);
        settle();
        check("alias_new_target", pred_target, 32'h180);

        next(); flush_all = 1; upd(32'h200, 0, 1, 32'h240, 0, 0); look(32'h80);
        settle();
        check("flush_cycle_old_view", pred_taken, 1);
        next(); look(32'h80);
        settle();
        check("flushed_80", pred_target, 32'h84);
        next(); look(32'h200);
        settle();
        check("flush_no_alloc_200", pred_target, 32'h204);

        next(); upd(32'h500, 1, 1, 32'h400, 1, 32'h300);
        settle();
        check("jr_mispredict", mispredict, 1);
        check("jr_correct_pc", correct_pc, 32'h400);
        next(); look(32'h500);
        settle();
        check("jr_target", pred_target, 32'h400);
        next(); upd(32'h500, 1, 1, 32'h480, 1, 32'h400);
        next(); look(32'h500);
        settle();
        check("jr_retarget", pred_target, 32'h480);
        next(); upd(32'h500, 1, 1, 32'h480, 1, 32'h480);
        settle();
        check("jr_correct_no_redirect", mispredict, 0);
        next(); upd(32'h600, 0, 0, 0, 1, 32'h700);
        settle();
        check("nt_redirect", mispredict, 1);
        check("nt_correct_pc", correct_pc, 32'h604);
        next(); look(32'hFFFF_FFFC);
        settle();
        check("pc_wrap", pred_target, 32'h0);

        next(); look(32'h500);
        #1 rst = 1'b0;
        #1;
        check("async_rst_taken", pred_taken, 0);
        check("async_rst_target", pred_target, 32'h504);
        check("async_rst_lookup_count", lookup_count, 0);
        check("async_rst_mispredict_count", mispredict_count, 0);
        @(negedge clk);
        rst = 1'b1;
        settle();
        check("post_rst_miss", pred_taken, 0);
        next();
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
